// File: rtl/operand_fetch.sv
// Operand fetch: 8x16 register file with write forwarding feeding a 2-entry operand FIFO.
// Latency 1 cycle accept-to-output; rd_ready drops only when the FIFO holds 2 entries.

module of_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push_rdy = (cnt < FULL);
    assign pop_vld  = (cnt != '0);
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module operand_fetch #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_num,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [2:0]       rd_num_a,
    input  logic [2:0]       rd_num_b,
    input  logic [1:0]       shift_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [1:0]       out_shift
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       shift;
    } operand_t;

    logic [WIDTH-1:0] rf [8];
    operand_t         cap;
    operand_t         head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_num] <= wr_data;
        end
    end

    // Same-cycle writes bypass the array so the captured operand is never stale.
    always_comb begin
        cap       = '0;
        cap.a     = (wr_en && (wr_num == rd_num_a)) ? wr_data : rf[rd_num_a];
        cap.b     = (wr_en && (wr_num == rd_num_b)) ? wr_data : rf[rd_num_b];
        cap.shift = shift_in;
    end

    of_fifo #(
        .W     ($bits(operand_t)),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_valid),
        .push_rdy (rd_ready),
        .push_dat (cap),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head)
    );

    assign out_a     = out_valid ? head.a     : '0;
    assign out_b     = out_valid ? head.b     : '0;
    assign out_shift = out_valid ? head.shift : '0;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a register-file model and an expected-operand queue.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_num;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  rd_num_a;
    logic [2:0]  rd_num_b;
    logic [1:0]  shift_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [1:0]  out_shift;

    logic [15:0] mrf [8];
    logic [33:0] q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          pops0;

    always #5 clk = ~clk;

    operand_fetch #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_num_a  (rd_num_a),
        .rd_num_b  (rd_num_b),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_shift (out_shift)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fwd(input logic [2:0] n);
        return (wr_en && wr_num == n) ? wr_data : mrf[n];
    endfunction

    // Checks outputs against the model, then advances DUT and model by one edge.
    task automatic cycle();
        logic [33:0] e;
        logic [33:0] hd;
        logic        acc;
        logic        pp;
        hd = (q.size() > 0) ? q[0] : 34'h0;
        chk("rd_ready", 32'(rd_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_a", 32'(out_a), 32'(hd[33:18]));
        chk("out_b", 32'(out_b), 32'(hd[17:2]));
        chk("out_shift", 32'(out_shift), 32'(hd[1:0]));
        acc = rd_valid && (q.size() < 2);
        pp  = (q.size() > 0) && out_ready;
        e   = {fwd(rd_num_a), fwd(rd_num_b), shift_in};
        @(posedge clk);
        if (pp) begin
            void'(q.pop_front());
            n_pops++;
        end
        if (acc) q.push_back(e);
        if (wr_en) mrf[wr_num] = wr_data;
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [2:0] wn, input logic [15:0] wd,
                         input logic rv, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [1:0] sh, input logic ordy);
        wr_en = we; wr_num = wn; wr_data = wd;
        rd_valid = rv; rd_num_a = ra; rd_num_b = rb; shift_in = sh;
        out_ready = ordy;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 0; wr_num = 0; wr_data = 0;
        rd_valid = 0; rd_num_a = 0; rd_num_b = 0; shift_in = 0; out_ready = 0;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then fetch A=R3, B=R5
        drive(0, 0, 0, 1, 3, 5, 0, 0);
        chk("r038_valid", 32'(out_valid), 32'd1);
        chk("r038_a", 32'(out_a), 32'h0);
        chk("r038_b", 32'(out_b), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Forwarding on both operands from the same register
        drive(1, 2, 16'h8001, 1, 2, 2, 2'b11, 1);
        chk("r039_a", 32'(out_a), 32'h8001);
        chk("r039_b", 32'(out_b), 32'h8001);
        chk("r039_shift", 32'(out_shift), 32'h3);
        drive(1, 6, 16'h00AA, 1, 6, 2, 2'b01, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: three offers, two accepted
        drive(0, 0, 0, 1, 2, 6, 2'b01, 0);
        drive(0, 0, 0, 1, 6, 2, 2'b10, 0);
        drive(0, 0, 0, 1, 1, 1, 2'b00, 0);
        chk("r040_full", 32'(rd_ready), 32'd0);
        chk("r040_head", 32'(out_a), 32'h8001);
        drive(0, 0, 0, 1, 3, 3, 2'b11, 1);
        chk("r040_entry2", 32'(out_a), 32'h00AA);
        chk("r040_ready", 32'(rd_ready), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Stale capture across a later register write
        drive(1, 4, 16'h1234, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 4, 2'b10, 0);
        drive(1, 4, 16'hFFFF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r041_stale", 32'(out_b), 32'h1234);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Streaming eight back-to-back fetches
        for (int i = 0; i < 8; i++) drive(1, 3'(i), 16'(1 << i), 0, 0, 0, 0, 1);
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 3'(i), 3'(7 - i), 2'(i), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("r042_pops", 32'(n_pops - pops0), 32'd8);

        // Reset with a full buffer and a write/accept pending
        drive(0, 0, 0, 1, 7, 6, 2'b01, 0);
        drive(0, 0, 0, 1, 5, 4, 2'b10, 0);
        chk("r043_full", 32'(rd_ready), 32'd0);
        wr_en = 1; wr_num = 1; wr_data = 16'h5555;
        rd_valid = 1; rd_num_a = 1; rd_num_b = 1;
        rst_n = 1'b0;
        #1;
        chk("r043_valid", 32'(out_valid), 32'd0);
        chk("r043_ready", 32'(rd_ready), 32'd1);
        chk("r043_a", 32'(out_a), 32'h0);
        chk("r043_b", 32'(out_b), 32'h0);
        chk("r043_shift", 32'(out_shift), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 0; rd_valid = 0;
        q.delete();
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
        drive(0, 0, 0, 1, 0, 1, 0, 1);
        chk("r043_r1", 32'(out_b), 32'h0);
        drive(0, 0, 0, 1, 2, 3, 0, 1);
        drive(0, 0, 0, 1, 4, 5, 0, 1);
        drive(0, 0, 0, 1, 6, 7, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: WIDTH, 16, data width of registers and operands; only 16 is verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_en  input  1  register-file write strobe.
REQ-005 wr_num  input  3  register index to write.
REQ-006 wr_data  input  WIDTH  write data.
REQ-007 rd_valid  input  1  upstream requests an operand fetch.
REQ-008 rd_ready  output  1  block can accept a fetch this cycle.
REQ-009 rd_num_a  input  3  index of operand A.
REQ-010 rd_num_b  input  3  index of operand B.
REQ-011 shift_in  input  2  shift code carried with the fetch, unmodified.
REQ-012 out_valid  output  1  out_a, out_b and out_shift hold a valid operand set.
REQ-013 out_ready  input  1  downstream shifter/ALU stage consumes the head entry.
REQ-014 out_a  output  WIDTH  operand A.
REQ-015 out_b  output  WIDTH  operand B, which feeds the shifter input.
REQ-016 out_shift  output  2  shift code for operand B.

Function
REQ-017 Register file SHALL hold 8 registers of WIDTH bits, R0-R7, all writable, with no hardwired zero.
REQ-018 wr_en=1 SHALL write wr_data into R[wr_num] at the clock edge.
REQ-019 A fetch SHALL be accepted on any edge where rd_valid=1 and rd_ready=1.
REQ-020 An accepted fetch SHALL capture {R[rd_num_a], R[rd_num_b], shift_in} into a 2-entry FIFO operand buffer.
REQ-021 Write forwarding: if wr_en=1 and wr_num equals a read index in the accept cycle, the captured operand SHALL be wr_data.
REQ-022 Forwarding SHALL apply independently to A and B, including the case rd_num_a = rd_num_b = wr_num.
REQ-023 Captured entries SHALL NOT change when registers are written later.
REQ-024 rd_ready SHALL be 1 if and only if the buffer count is less than 2; it depends only on count, not on out_ready.
REQ-025 out_valid SHALL be 1 if and only if the count is at least 1.
REQ-026 The outputs SHALL present the oldest entry.
REQ-027 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-028 While out_valid=1 and out_ready=0, the outputs SHALL remain stable.
REQ-029 Count update rules:
- accept only: count+1;
- pop only: count-1;
- accept and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-030 Accept-to-output latency SHALL be 1 cycle: an accept at edge N into an empty buffer gives out_valid=1 after edge N.
REQ-031 Full-buffer throughput: with count=2 and a pop, no accept occurs in that cycle; rd_ready becomes 1 in the next cycle.
REQ-032 Sustained rd_valid=1 and out_ready=1 SHALL give one fetch per cycle.
REQ-033 out_a, out_b and out_shift SHALL be 0 when out_valid=0.
REQ-034 rd_valid=0 or rd_ready=0 SHALL leave the buffer unchanged; register writes still proceed.

Reset
REQ-035 On rst_n=0, asynchronously:
- all registers SHALL clear to 0;
- count SHALL be 0;
- out_valid=0 and out_a/out_b/out_shift=0;
- rd_ready SHALL be 1 once count=0.
REQ-036 Reset mid-operation SHALL discard buffered entries and SHALL NOT let any write or accept in that cycle take effect.
REQ-037 After rst_n deasserts, the first edge SHALL behave as normal operation.

Verification
REQ-038 Reset then fetch: fetch A=R3, B=R5 -> next cycle out_valid=1, out_a=0x0000, out_b=0x0000.
REQ-039 Forwarding:
- write R2=0x8001 and fetch A=R2, B=R2, shift_in=2'b11 in the same cycle;
- expect out_a=0x8001, out_b=0x8001, out_shift=2'b11.
REQ-040 Backpressure:
- out_ready=0 with three fetches offered;
- expect two accepted and rd_ready=0;
- the outputs stay on entry 1;
- raise out_ready for one cycle -> entry 2 shown, rd_ready=1 next cycle.
REQ-041 Stale capture:
- R4=0x1234 fetched and stalled;
- then write R4=0xFFFF;
- expect out_b still 0x1234 until popped.
REQ-042 Streaming: R0-R7 preloaded with 0x0001 through 0x0080; fetching 8 back-to-back with out_ready=1 -> one pop per cycle, in order.
REQ-043 Reset asserted with count=2 -> out_valid=0 immediately and all registers read 0 after reset.
